// File: rtl/smart_bus_driver.sv
// Row-edge smart bus transmitter: buffers operand words and drives each onto the
// shared horizontal bus together with the destination column select(s).
module smart_bus_driver #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned NUM_COLS   = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 0,
  localparam int unsigned COL_W     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic [COL_W-1:0]     in_col,
  input  logic                 in_bcast,
  input  logic                 hold,
  output logic [WORD_SIZE-1:0] horizontal_smart_bus_out,
  output logic [NUM_COLS-1:0]  select_left_in_smart,
  output logic                 busy,
  output logic [15:0]          words_sent,
  output logic                 col_err
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = WORD_SIZE + COL_W + 1;
  localparam int unsigned GAP_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [GAP_W-1:0]     gap_cnt, gap_next;

  logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;

  logic                 push, pop, drive_done;
  logic [ENTRY_W-1:0]   head;
  logic [WORD_SIZE-1:0] head_data;
  logic [COL_W-1:0]     head_col;
  logic                 head_bcast, head_bad;

  logic [WORD_SIZE-1:0] bus_next;
  logic [NUM_COLS-1:0]  sel_next;
  logic [15:0]          sent_next;
  logic                 err_next;

  // Ready depends only on the registered count, so a same-edge pop never frees a slot early.
  assign in_ready   = (count != CNT_W'(FIFO_DEPTH));
  assign push       = in_valid & in_ready;
  assign head       = mem[rd_ptr];
  assign head_data  = head[ENTRY_W-1 -: WORD_SIZE];
  assign head_col   = head[COL_W:1];
  assign head_bcast = head[0];
  assign head_bad   = !head_bcast && (32'(head_col) >= NUM_COLS);
  assign busy       = (count != '0) || (state != IDLE);

  assign drive_done = (state == DRIVE) && !hold;
  assign pop        = !hold && (count != '0) &&
                      ((state == IDLE) || ((state == DRIVE) && (GAP_CYCLES == 0)));

  // Buffer storage; contents are don't-care until counted in.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_data, in_col, in_bcast};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_next;
    end
  end

  // The IDLE cycle that follows GAP is the last enforced idle cycle, so GAP itself
  // lasts GAP_CYCLES-1 cycles and GAP_CYCLES=1 returns straight to IDLE.
  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    case (state)
      IDLE: begin
        if (pop) state_next = DRIVE;
      end
      DRIVE: begin
        if (!hold) begin
          if (GAP_CYCLES > 1) begin
            state_next = GAP;
            gap_next   = GAP_W'(GAP_CYCLES - 1);
          end else if (pop) begin
            state_next = DRIVE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      GAP: begin
        if (!hold) begin
          if (gap_cnt <= GAP_W'(1)) begin
            state_next = IDLE;
            gap_next   = '0;
          end else begin
            gap_next   = gap_cnt - GAP_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        gap_next   = '0;
      end
    endcase
  end

  // Bus keeps its last value between words; only the selects drop back to zero.
  always_comb begin
    bus_next  = horizontal_smart_bus_out;
    sel_next  = select_left_in_smart;
    sent_next = words_sent;
    err_next  = col_err;
    if (pop) begin
      bus_next = head_data;
      if (head_bcast)    sel_next = '1;
      else if (head_bad) sel_next = '0;
      else               sel_next = NUM_COLS'(1) << head_col;
      err_next = col_err | head_bad;
    end else if (drive_done) begin
      sel_next = '0;
    end
    if (drive_done) sent_next = words_sent + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      horizontal_smart_bus_out <= '0;
      select_left_in_smart     <= '0;
      words_sent               <= '0;
      col_err                  <= 1'b0;
    end else begin
      horizontal_smart_bus_out <= bus_next;
      select_left_in_smart     <= sel_next;
      words_sent               <= sent_next;
      col_err                  <= err_next;
    end
  end

endmodule

// File: tb/tb_smart_bus_driver.sv
// Bench for smart_bus_driver: three configurations share one stimulus stream and
// are each compared every cycle against a queue-based reference model.
module tb_smart_bus_driver;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_bcast, hold;
  logic [15:0] in_data;
  logic [2:0]  in_col;

  logic        rdy_o [3];
  logic        busy_o[3];
  logic        err_o [3];
  logic [15:0] bus_o [3];
  logic [15:0] sent_o[3];
  logic [7:0]  sel_a, sel_c;
  logic [5:0]  sel_b;
  logic [7:0]  sel_o [3];

  always #5 clk = ~clk;

  smart_bus_driver dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_o[0]), .in_data(in_data),
    .in_col(in_col), .in_bcast(in_bcast), .hold(hold), .horizontal_smart_bus_out(bus_o[0]),
    .select_left_in_smart(sel_a), .busy(busy_o[0]), .words_sent(sent_o[0]), .col_err(err_o[0]));

  smart_bus_driver #(.NUM_COLS(6), .GAP_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_o[1]), .in_data(in_data),
    .in_col(in_col), .in_bcast(in_bcast), .hold(hold), .horizontal_smart_bus_out(bus_o[1]),
    .select_left_in_smart(sel_b), .busy(busy_o[1]), .words_sent(sent_o[1]), .col_err(err_o[1]));

  smart_bus_driver #(.GAP_CYCLES(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_o[2]), .in_data(in_data),
    .in_col(in_col), .in_bcast(in_bcast), .hold(hold), .horizontal_smart_bus_out(bus_o[2]),
    .select_left_in_smart(sel_c), .busy(busy_o[2]), .words_sent(sent_o[2]), .col_err(err_o[2]));

  assign sel_o[0] = sel_a;
  assign sel_o[1] = {2'b00, sel_b};
  assign sel_o[2] = sel_c;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  c;
    logic        b;
  } ent_t;

  // Reference model: per configuration a word queue, a drive flag and a count of
  // idle cycles still owed before the next word may go out.
  ent_t        mq[3][$];
  int          ncols[3] = '{8, 6, 8};
  int          ngap [3] = '{0, 2, 1};
  logic [15:0] m_bus [3];
  logic [7:0]  m_sel [3];
  logic [15:0] m_sent[3];
  logic        m_err [3];
  bit          m_active[3];
  int          m_cool[3];

  int checks = 0;
  int errors = 0;

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      ent_t e;
      int   pre;
      bit   can_pop, ended;
      if (!rst) begin
        mq[i].delete();
        m_bus[i] = '0; m_sel[i] = '0; m_sent[i] = '0; m_err[i] = 1'b0;
        m_active[i] = 1'b0; m_cool[i] = 0;
      end else begin
        pre = mq[i].size();
        can_pop = 1'b0;
        ended = 1'b0;
        if (!hold) begin
          if (m_active[i]) begin
            m_sent[i]   = m_sent[i] + 16'd1;
            m_active[i] = 1'b0;
            ended       = 1'b1;
            m_cool[i]   = ngap[i];
            can_pop     = (ngap[i] == 0);
          end else begin
            if (m_cool[i] > 0) m_cool[i]--;
            can_pop = (m_cool[i] == 0);
          end
          if (can_pop && pre > 0) begin
            e = mq[i].pop_front();
            m_active[i] = 1'b1;
            m_bus[i] = e.d;
            if (e.b)                  m_sel[i] = 8'hFF >> (8 - ncols[i]);
            else if (e.c < ncols[i])  m_sel[i] = 8'(1) << e.c;
            else begin
              m_sel[i] = 8'h00;
              m_err[i] = 1'b1;
            end
          end else if (ended) begin
            m_sel[i] = 8'h00;
          end
        end
        if (in_valid && pre < 4) mq[i].push_back('{d: in_data, c: in_col, b: in_bcast});
      end
    end
  endtask

  task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("bus",   i, 32'(bus_o[i]),  32'(m_bus[i]));
      chk("sel",   i, 32'(sel_o[i]),  32'(m_sel[i]));
      chk("sent",  i, 32'(sent_o[i]), 32'(m_sent[i]));
      chk("err",   i, 32'(err_o[i]),  32'(m_err[i]));
      chk("ready", i, 32'(rdy_o[i]),  32'(mq[i].size() < 4));
      if (m_cool[i] == 0)
        chk("busy", i, 32'(busy_o[i]), 32'((mq[i].size() > 0) || m_active[i]));
    end
  endtask

  task automatic step(bit r, bit v, logic [15:0] d, logic [2:0] c, bit b, bit h);
    rst = r; in_valid = v; in_data = d; in_col = c; in_bcast = b; hold = h;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_col = '0; in_bcast = 1'b0; hold = 1'b0;
    @(negedge clk);

    // Reset held with valid high captures nothing.
    step(1'b0, 1'b1, 16'hDEAD, 3'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'hBEEF, 3'd2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    chk("rst_sel",   0, 32'(sel_a),     32'h0);
    chk("rst_ready", 0, 32'(rdy_o[0]),  32'h1);
    chk("rst_sent",  0, 32'(sent_o[0]), 32'h0);

    // Single word to column 3.
    step(1'b1, 1'b1, 16'h1234, 3'd3, 1'b0, 1'b0);
    chk("single_pending", 0, 32'(sel_a), 32'h0);
    step(1'b1, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    chk("single_sel", 0, 32'(sel_a),    32'h08);
    chk("single_bus", 0, 32'(bus_o[0]), 32'h1234);
    step(1'b1, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    chk("single_off",  0, 32'(sel_a),     32'h0);
    chk("single_keep", 0, 32'(bus_o[0]),  32'h1234);
    chk("single_cnt",  0, 32'(sent_o[0]), 32'h1);
    chk("single_busy", 0, 32'(busy_o[0]), 32'h0);
    idle(4);

    // Fill to full under hold, fifth word waits for the first pop.
    step(1'b1, 1'b1, 16'h1000, 3'd0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 16'h1001, 3'd1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 16'h1002, 3'd2, 1'b0, 1'b1);
    step(1'b1, 1'b1, 16'h1003, 3'd3, 1'b0, 1'b1);
    chk("full_ready", 0, 32'(rdy_o[0]), 32'h0);
    step(1'b1, 1'b1, 16'h1007, 3'd7, 1'b0, 1'b1);
    step(1'b1, 1'b1, 16'h1007, 3'd7, 1'b0, 1'b0);
    chk("b2b_first", 0, 32'(sel_a), 32'h01);
    step(1'b1, 1'b1, 16'h1007, 3'd7, 1'b0, 1'b0);
    chk("b2b_second", 0, 32'(sel_a), 32'h02);
    idle(3);
    chk("b2b_last", 0, 32'(sel_a), 32'h80);
    idle(12);
    chk("b2b_cnt", 0, 32'(sent_o[0]), 32'd6);

    // Broadcast then column 0; configuration b enforces two idle cycles.
    step(1'b1, 1'b1, 16'hAAAA, 3'd4, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h5555, 3'd0, 1'b0, 1'b0);
    chk("bcast_sel", 1, 32'(sel_o[1]), 32'h3F);
    step(1'b1, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    chk("gap_sel0", 1, 32'(sel_o[1]), 32'h0);
    step(1'b1, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    chk("gap_sel1", 1, 32'(sel_o[1]), 32'h0);
    step(1'b1, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    chk("gap_next", 1, 32'(sel_o[1]), 32'h01);
    idle(8);

    // Hold for three cycles while column 5 is being driven.
    step(1'b1, 1'b1, 16'h0505, 3'd5, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    chk("hold_sel", 0, 32'(sel_a), 32'h20);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 16'h0, 3'd0, 1'b0, 1'b1);
      chk("hold_sel_frozen", 0, 32'(sel_a),     32'h20);
      chk("hold_cnt_frozen", 0, 32'(sent_o[0]), 32'd8);
    end
    step(1'b1, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    chk("hold_release_sel", 0, 32'(sel_a),     32'h0);
    chk("hold_release_cnt", 0, 32'(sent_o[0]), 32'd9);
    idle(8);

    // Column 7 is out of range for the six-column configuration.
    step(1'b1, 1'b1, 16'h7777, 3'd7, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h2222, 3'd2, 1'b0, 1'b0);
    chk("badcol_bus", 1, 32'(bus_o[1]), 32'h7777);
    chk("badcol_sel", 1, 32'(sel_o[1]), 32'h0);
    chk("badcol_err", 1, 32'(err_o[1]), 32'h1);
    idle(3);
    chk("goodcol_sel", 1, 32'(sel_o[1]), 32'h04);
    chk("err_sticky",  1, 32'(err_o[1]), 32'h1);
    chk("err_clean",   0, 32'(err_o[0]), 32'h0);

    // Randomized traffic with hold, broadcast and occasional mid-run reset.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 2) != 0),
           16'($urandom),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0));
    end
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
